// File: rtl/dist_ram_lane.sv
// One lane of the upsizing FIFO: simple dual-port distributed RAM,
// synchronous write, asynchronous (combinational) read. No reset on contents.
module dist_ram_lane #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: store on the rising edge when enabled.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/upsize_dist_ram_fifo.sv
// Width-converting FIFO: narrow writes are packed lane by lane into wide
// entries; a wide entry becomes readable (first-word-fall-through) once its
// last lane is written. Lane 0 holds the first narrow word (LSBs).
module upsize_dist_ram_fifo #(
  parameter  int IN_WIDTH   = 16,
  parameter  int RATIO      = 4,
  parameter  int ADDR_WIDTH = 5,
  localparam int DEPTH      = 1 << ADDR_WIDTH,
  localparam int OUT_WIDTH  = IN_WIDTH * RATIO,
  localparam int LANE_W     = (RATIO > 2) ? $clog2(RATIO) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [IN_WIDTH-1:0]   wr_data,
  output logic                  full,
  input  logic                  rd_en,
  output logic [OUT_WIDTH-1:0]  rd_data,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic [LANE_W-1:0]     lane_fill,
  output logic                  wr_err,
  output logic                  rd_err
);

  localparam logic [LANE_W-1:0]   LAST_LANE = LANE_W'(RATIO - 1);
  localparam logic [ADDR_WIDTH:0] COUNT_MAX = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [LANE_W-1:0]     lane;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  commit;

  // Flags come only from registered count, so they never glitch on inputs.
  assign empty     = (count == '0);
  assign full      = (count == COUNT_MAX);
  assign lane_fill = lane;

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;
  assign commit = wr_acc && (lane == LAST_LANE);

  // Pointers, lane counter, committed-word count and error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr <= '0;
      rd_addr <= '0;
      lane    <= '0;
      count   <= '0;
      wr_err  <= 1'b0;
      rd_err  <= 1'b0;
    end else begin
      wr_err <= wr_en && full;
      rd_err <= rd_en && empty;
      if (wr_acc) begin
        if (lane == LAST_LANE) begin
          lane    <= '0;
          wr_addr <= wr_addr + 1'b1;
        end else begin
          lane <= lane + 1'b1;
        end
      end
      if (rd_acc) rd_addr <= rd_addr + 1'b1;
      if (commit && !rd_acc) count <= count + 1'b1;
      else if (!commit && rd_acc) count <= count - 1'b1;
    end
  end

  // One RAM per lane; only the lane currently being filled is written.
  for (genvar k = 0; k < RATIO; k++) begin : g_lane
    dist_ram_lane #(
      .WIDTH      (IN_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_lane (
      .clk     (clk),
      .we      (wr_acc && (lane == LANE_W'(k))),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data[k*IN_WIDTH +: IN_WIDTH])
    );
  end

endmodule

// File: doc/upsize_dist_ram_fifo.md
Name: upsize_dist_ram_fifo

Overview:
- Width-converting FIFO for the different-widths FIFO family.
- Accepts narrow words of IN_WIDTH bits and presents wide words of IN_WIDTH*RATIO bits, with first-word-fall-through.
- Storage is RATIO lanes of simple dual-port distributed RAM: synchronous write, asynchronous read.
- Sits between narrow producers (per-element streams) and wide consumers (memory-word packers).

Parameters:
- IN_WIDTH, 16, narrow write word width.
- RATIO, 4, narrow words per wide word; >=2; any integer, not necessarily a power of two.
- ADDR_WIDTH, 5, wide-entry address width.
- DEPTH, 1<<ADDR_WIDTH, wide entries. Derived; do not override.
- OUT_WIDTH, IN_WIDTH*RATIO, read word width. Derived.
- LANE_W, max(1,clog2(RATIO)), lane index width. Derived.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  push one narrow word.
- wr_data  in  IN_WIDTH  narrow word.
- full  out  1  no room for a narrow write.
- rd_en  in  1  pop one wide word.
- rd_data  out  OUT_WIDTH  head wide word; valid while empty=0.
- empty  out  1  no complete wide word available.
- count  out  ADDR_WIDTH+1  complete wide words stored, 0..DEPTH.
- lane_fill  out  LANE_W  narrow words in the current partial wide word, 0..RATIO-1.
- wr_err  out  1  one-cycle pulse: write attempted while full.
- rd_err  out  1  one-cycle pulse: read attempted while empty.

Behaviour:
- Reset: rst_n low clears all state immediately, regardless of clk.
  - Cleared: wr_addr=0, rd_addr=0, lane=0, count=0, wr_err=0, rd_err=0.
  - Outputs: empty=1, full=0, lane_fill=0.
  - RAM contents are not reset. rd_data is don't-care while empty=1.
  - Reset mid-operation discards any partial wide word.
- Accepted write (wr_en && !full):
  - wr_data is stored in lane `lane` at wr_addr.
  - If lane==RATIO-1: lane returns to 0 and wr_addr increments, wrapping modulo DEPTH. The wide word is committed.
  - Otherwise lane increments.
- Lane order: the first narrow word of a wide word occupies rd_data[IN_WIDTH-1:0]; lane k occupies bits [(k+1)*IN_WIDTH-1 : k*IN_WIDTH].
- Accepted read (rd_en && !empty): rd_addr increments, wrapping modulo DEPTH.
- count update:
  - +1 on a commit without a read.
  - -1 on a read without a commit.
  - Unchanged when a commit and a read occur in the same cycle.
- Flag decode: empty = (count==0); full = (count==DEPTH). Both are decoded from registered count, so the flags are glitch-free with respect to the inputs.
- Full-state writes: while full=1, writes are rejected even if a read happens in the same cycle; the space appears on the next cycle. The lane being written always lives in slot wr_addr, which is free iff count<DEPTH.
- Latency: the commit on edge N gives empty=0 and valid rd_data after edge N (one cycle from the final narrow write). rd_data is the asynchronous RAM read at rd_addr.
- rd_data after a read: when a read and the final write of the next word occur on edge N, rd_data shows the next word after edge N, provided count stays >0.
- Error pulses: wr_err and rd_err are registered. They go high for the one cycle after the rejected request and do not change any pointer.
- Simultaneous read and partial write: both proceed independently; count and empty are unaffected by the partial write.

Decomposition:
- No shared package; all widths are derived locally from the parameters.
- One natural sub-module: dist_ram_lane, an IN_WIDTH x DEPTH simple dual-port distributed RAM with synchronous write and asynchronous read.
  - The top level generates RATIO instances.
  - Lane k has its write enable gated by (lane==k) and shares wr_addr/rd_addr.
  - Lane k's read output drives the rd_data slice for lane k.
- The top level holds the pointers, lane counter, count register and error registers.

Test Plan (IN_WIDTH=8, RATIO=4, ADDR_WIDTH=2):
- Reset: hold rst_n=0 -> empty=1, full=0, count=0, lane_fill=0, wr_err=rd_err=0.
- Pack and pop:
  - Write 0x11,0x22,0x33,0x44 on consecutive cycles -> lane_fill 1,2,3,0; empty=0 after the 4th edge; rd_data=0x44332211; count=1.
  - rd_en for 1 cycle -> empty=1, count=0.
- Fill, overflow, wrap:
  - Write 0x00..0x0F -> full=1 and count=4 after the 16th edge.
  - Write 0xFF -> ignored; wr_err=1 for exactly one cycle.
  - Drain -> rd_data 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C in order.
  - Repeat the fill/drain 3 times to exercise pointer wrap; data matches each round.
- Simultaneous commit and read:
  - Start at count=1, lane_fill=3; write 0xAA while rd_en=1 -> count stays 1; rd_data becomes the word whose MSB byte is 0xAA.
  - Also, from count=4: read and write together -> write rejected, wr_err=1, count=3.
- Underflow: rd_en=1 while empty -> rd_err=1 for exactly one cycle; count=0; a following 4-word write yields the correct rd_data.
- Reset mid-operation:
  - Write 0x55,0x66, then pull rst_n low between edges -> empty=1 and lane_fill=0 immediately.
  - After release, write 0x01..0x04 -> rd_data=0x04030201.
